// File: rtl/seq_mult_ctrl.sv
// -----------------------------------------------------------------------------
// seq_mult_ctrl
// -----------------------------------------------------------------------------
// Multi-cycle unsigned shift-and-add multiplier with its own sequencing FSM.
//
// A single (N+M)-bit adder is reused once per multiplier bit. This trades a
// combinational array multiplier for M cycles of latency.
//
// Handshake: a start request is accepted on a rising clk edge when the FSM is
// in IDLE or DONE (start=1 at that edge). In CALC, start is ignored. busy is
// high for every CALC cycle. done is high for exactly one cycle (DONE), and y
// carries the new product in that same cycle. y then holds until the next
// done. Operands may change freely after the accepting edge.
//
// Parameters:
//   N  width of multiplicand a
//   M  width of multiplier b (also the maximum number of CALC cycles)
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset (aborts any operation, y -> 0)
//   start  in   request, sampled on rising clk edge
//   a      in   [N-1:0]   multiplicand, captured on accepted start
//   b      in   [M-1:0]   multiplier, captured on accepted start
//   busy   out  high while in CALC
//   done   out  one-cycle pulse, y valid in that cycle
//   y      out  [N+M-1:0] product, held until the next done
//
// Build option:
//   SEQ_MULT_EARLY_EXIT_EN  when defined, CALC ends as soon as the remaining
//                           multiplier bits are all zero. Without it, every
//                           operation spends exactly M cycles in CALC.
//
// The FSM state is kept in state_q. It is readable hierarchically for
// checkers and is decoded directly onto busy/done.
// -----------------------------------------------------------------------------
module seq_mult_ctrl #(
  parameter int N = 4,
  parameter int M = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [M-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [N+M-1:0] y
);

  localparam int W  = N + M;
  // The step counter only needs to reach M-1.
  localparam int SW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  acc_q,   acc_d;
  logic [W-1:0]  a_q,     a_d;
  logic [M-1:0]  b_q,     b_d;
  logic [SW-1:0] step_q,  step_d;
  logic [W-1:0]  y_q,     y_d;

  // Datapath for one CALC iteration.
  logic [W-1:0]  addend;
  logic [W-1:0]  acc_sum;
  logic [M-1:0]  b_shift;
  logic          last_step;

  always_comb begin
    // Partial product for the current multiplier bit. The sum cannot
    // overflow W bits, because (2^N-1)(2^M-1) < 2^(N+M).
    addend    = b_q[0] ? (a_q << step_q) : '0;
    acc_sum   = acc_q + addend;
    b_shift   = b_q >> 1;
`ifdef SEQ_MULT_EARLY_EXIT_EN
    // Stop once no set bits remain. The step limit still bounds the loop.
    last_step = (step_q == SW'(M - 1)) || (b_shift == '0);
`else
    last_step = (step_q == SW'(M - 1));
`endif
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    step_d  = step_q;
    y_d     = y_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = {{M{1'b0}}, a};
          b_d     = b;
          acc_d   = '0;
          step_d  = '0;
          state_d = ST_CALC;
        end
      end

      ST_CALC: begin
        acc_d  = acc_sum;
        b_d    = b_shift;
        step_d = step_q + SW'(1);
        if (last_step) begin
          // Register the final sum into y on entry to DONE, so y is already
          // valid during the done cycle.
          y_d     = acc_sum;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        // A start here is accepted back-to-back. This is the only point
        // where a new operation can overlap the end of the old one.
        if (start) begin
          a_d     = {{M{1'b0}}, a};
          b_d     = b;
          acc_d   = '0;
          step_d  = '0;
          state_d = ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      step_q  <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      step_q  <= step_d;
      y_q     <= y_d;
    end
  end

  // Outputs decode straight from registered state. An asynchronous reset
  // therefore clears busy/done/y immediately.
  assign busy = (state_q == ST_CALC);
  assign done = (state_q == ST_DONE);
  assign y    = y_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_mult_ctrl
// -----------------------------------------------------------------------------
// Directed testbench for seq_mult_ctrl.
//
// Instances:
//   dut    N=4, M=4
//   dut8   N=8, M=4 (parameter override)
//
// Cycle numbering: the edge that samples start=1 is edge 0. Cycle k is the
// interval after edge k-1. Outputs are sampled on the falling edge. Inputs
// are driven on the falling edge, or 1ns after a rising edge.
//
// Expected products and done cycles are hand-computed constants. Done
// cycles are given for both builds of SEQ_MULT_EARLY_EXIT_EN.
// -----------------------------------------------------------------------------
module tb_seq_mult_ctrl;

  // ---------------------------------------------------------------- clock/reset
  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUT (4x4)
  logic        start = 1'b0;
  logic [3:0]  a     = '0;
  logic [3:0]  b     = '0;
  logic        busy;
  logic        done;
  logic [7:0]  y;

  seq_mult_ctrl #(.N(4), .M(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .y     (y)
  );

  // ---------------------------------------------------------------- DUT (8x4)
  logic        start8 = 1'b0;
  logic [7:0]  a8     = '0;
  logic [3:0]  b8     = '0;
  logic        busy8;
  logic        done8;
  logic [11:0] y8;

  seq_mult_ctrl #(.N(8), .M(4)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .busy  (busy8),
    .done  (done8),
    .y     (y8)
  );

  // ---------------------------------------------------------------- scoreboard
  int          checks   = 0;
  int          failures = 0;
  logic [11:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  // Issue one 4x4 operation with a single-cycle start pulse. Then follow
  // busy/done through to the done cycle, and one cycle beyond it.
  task automatic run_op(input logic [3:0] av, input logic [3:0] bv,
                        input logic [7:0] ey, input int d_off, input int d_on);
    int d;
`ifdef SEQ_MULT_EARLY_EXIT_EN
    d = d_on;
`else
    d = d_off;
`endif
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    exp_q.push_back(12'(ey));
    @(posedge clk);
    #1;
    start = 1'b0;
    // Operands may change freely after the accepting edge.
    a = 4'($urandom_range(0, 15));
    b = 4'($urandom_range(0, 15));
    for (int c = 1; c <= d; c++) begin
      @(negedge clk);
      if (c < d) begin
        check("calc_busy", busy, 1);
        check("calc_done", done, 0);
      end else begin
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        check("y_at_done", y, exp_q.pop_front());
      end
    end
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("y_hold_after", y, ey);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int d1;
    int d2;

    // Reset state.
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_y", y, 0);
    check("rst_y8", y8, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 5 x 3 = 15. Done in cycle 5; cycle 3 with early exit.
    run_op(4'd5, 4'd3, 8'd15, 5, 3);

    // 15 x 15 = 225. b has bit 3 set, so no early exit is possible.
    run_op(4'd15, 4'd15, 8'd225, 5, 5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_y_hold", y, 225);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
    end

    // Zero operands.
    run_op(4'd9, 4'd0, 8'd0, 5, 2);
    run_op(4'd0, 4'd9, 8'd0, 5, 5);

    // Back-to-back: start held high. 7x6 then 3x11, with junk operands
    // presented during CALC (start ignored there).
`ifdef SEQ_MULT_EARLY_EXIT_EN
    d1 = 4;
    d2 = 9;
`else
    d1 = 5;
    d2 = 10;
`endif
    @(negedge clk);
    a     = 4'd7;
    b     = 4'd6;
    start = 1'b1;
    exp_q.push_back(12'd42);
    exp_q.push_back(12'd33);
    for (int c = 1; c <= d2; c++) begin
      @(negedge clk);
      if (c == d1 || c == d2) begin
        check("b2b_done", done, 1);
        check("b2b_y", y, exp_q.pop_front());
      end else begin
        check("b2b_busy", busy, 1);
        check("b2b_no_done", done, 0);
      end
      if (c == d1) begin
        a = 4'd3;
        b = 4'd11;
      end else begin
        a = 4'($urandom_range(0, 15));
        b = 4'($urandom_range(0, 15));
      end
      if (c == d2) start = 1'b0;
    end
    @(negedge clk);
    check("b2b_idle", busy, 0);
    check("b2b_y_hold", y, 33);

    // Parameter override N=8, M=4: 200 x 13 = 2600, done in cycle 5.
    @(negedge clk);
    a8     = 8'd200;
    b8     = 4'd13;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c < 5) begin
        check("n8_busy", busy8, 1);
      end else begin
        check("n8_done", done8, 1);
        check("n8_y", y8, 2600);
      end
    end

    // Asynchronous reset mid-CALC (cycle 2 of 12x13).
    @(negedge clk);
    a     = 4'd12;
    b     = 4'd13;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("mid_busy_c1", busy, 1);
    @(posedge clk);
    #2;
    check("mid_busy_c2", busy, 1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_y", y, 0);
    check("arst_y8", y8, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_rst_no_done", done, 0);
      check("post_rst_no_busy", busy, 0);
    end
    run_op(4'd12, 4'd13, 8'd156, 5, 5);

    check("queue_empty", exp_q.size(), 0);

    // ---------------------------------------------------------------- report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
